// File: rtl/dcache_pkg.sv
// Shared types and default geometry for the write-through data cache controller.
package dcache_pkg;

    localparam int DEF_INDEX_W  = 5;
    localparam int DEF_OFFSET_W = 2;
    localparam int WORD_LSB     = 2;
    localparam int DEF_TAG_W    = 32 - WORD_LSB - DEF_OFFSET_W - DEF_INDEX_W;

    // Field positions of the default geometry within a byte address.
    localparam int DEF_INDEX_LSB = WORD_LSB + DEF_OFFSET_W;
    localparam int DEF_TAG_LSB   = DEF_INDEX_LSB + DEF_INDEX_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_WRITE = 2'd2,
        ST_WDONE = 2'd3
    } state_e;

endpackage

// File: rtl/dcache_data_array.sv
// Cache data storage: combinational read, single synchronous write port, no reset.
module dcache_data_array
    import dcache_pkg::*;
#(
    parameter int INDEX_W  = DEF_INDEX_W,
    parameter int OFFSET_W = DEF_OFFSET_W
) (
    input  logic                clk,
    input  logic                we,
    input  logic [INDEX_W-1:0]  wr_index,
    input  logic [OFFSET_W-1:0] wr_offset,
    input  logic [31:0]         wdata,
    input  logic [INDEX_W-1:0]  rd_index,
    input  logic [OFFSET_W-1:0] rd_offset,
    output logic [31:0]         rdata
);

    localparam int WORDS = 1 << (INDEX_W + OFFSET_W);

    logic [31:0] words [WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            words[{wr_index, wr_offset}] <= wdata;
        end
    end

    assign rdata = words[{rd_index, rd_offset}];

endmodule

// File: rtl/dcache_wt_ctrl.sv
// Direct-mapped write-through, no-write-allocate data cache controller.
// Define DCACHE_STATS_EN to add saturating hit_cnt/miss_cnt output counters.
module dcache_wt_ctrl
    import dcache_pkg::*;
#(
    parameter int INDEX_W  = DEF_INDEX_W,
    parameter int OFFSET_W = DEF_OFFSET_W,
    parameter int TAG_W    = 32 - WORD_LSB - OFFSET_W - INDEX_W
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] cpu_addr,
    input  logic        cpu_read,
    input  logic        cpu_write,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);

    localparam int LINES     = 1 << INDEX_W;
    localparam int INDEX_LSB = WORD_LSB + OFFSET_W;
    localparam logic [OFFSET_W-1:0] LAST_BEAT = '1;

    state_e              state;
    logic [OFFSET_W-1:0] beat;
    logic [LINES-1:0]    valid;
    logic [TAG_W-1:0]    tag_arr [LINES];

    logic [TAG_W-1:0]    tag;
    logic [INDEX_W-1:0]  index;
    logic [OFFSET_W-1:0] offset;
    logic                hit;
    logic                fill_done;
    logic                arr_we;
    logic [OFFSET_W-1:0] arr_wr_offset;
    logic [31:0]         arr_wdata;
    logic [31:0]         arr_rdata;
    logic                addr_unused;

    assign tag         = cpu_addr[31 -: TAG_W];
    assign index       = cpu_addr[INDEX_LSB +: INDEX_W];
    assign offset      = cpu_addr[WORD_LSB +: OFFSET_W];
    assign addr_unused = ^cpu_addr[WORD_LSB-1:0];
    assign hit         = valid[index] && (tag_arr[index] == tag);
    assign fill_done   = (state == ST_FILL) && mem_ready && (beat == LAST_BEAT);

    // Fills write the returning beat; stores update the array only on a hit.
    assign arr_we        = mem_ready && ((state == ST_FILL) || ((state == ST_WRITE) && hit));
    assign arr_wr_offset = (state == ST_FILL) ? beat : offset;
    assign arr_wdata     = (state == ST_FILL) ? mem_rdata : cpu_wdata;

    dcache_data_array #(
        .INDEX_W  (INDEX_W),
        .OFFSET_W (OFFSET_W)
    ) u_data_array (
        .clk       (clk),
        .we        (arr_we),
        .wr_index  (index),
        .wr_offset (arr_wr_offset),
        .wdata     (arr_wdata),
        .rd_index  (index),
        .rd_offset (offset),
        .rdata     (arr_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            beat  <= '0;
            valid <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cpu_write) begin
                        state <= ST_WRITE;
                    end else if (cpu_read && !hit) begin
                        state <= ST_FILL;
                        beat  <= '0;
                    end
                end
                ST_FILL: begin
                    if (mem_ready) begin
                        beat <= beat + OFFSET_W'(1);
                        if (beat == LAST_BEAT) begin
                            valid[index] <= 1'b1;
                            state        <= ST_IDLE;
                        end
                    end
                end
                ST_WRITE: begin
                    if (mem_ready) begin
                        state <= ST_WDONE;
                    end
                end
                ST_WDONE: state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (fill_done) begin
            tag_arr[index] <= tag;
        end
    end

    // IDLE outputs are combinational so a hit costs no stall; reset forces them quiet.
    always_comb begin
        cpu_rdata = '0;
        stall     = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            ST_IDLE: begin
                if (rst_n) begin
                    if (cpu_write || (cpu_read && !hit)) begin
                        stall = 1'b1;
                    end else if (cpu_read) begin
                        cpu_rdata = arr_rdata;
                    end
                end
            end
            ST_FILL: begin
                stall    = 1'b1;
                mem_req  = 1'b1;
                mem_addr = {tag, index, beat, 2'b00};
            end
            ST_WRITE: begin
                stall     = 1'b1;
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {cpu_addr[31:2], 2'b00};
                mem_wdata = cpu_wdata;
            end
            default: begin
            end
        endcase
    end

`ifdef DCACHE_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if ((state == ST_IDLE) && cpu_read && !cpu_write) begin
            if (hit && (hit_cnt != '1)) begin
                hit_cnt <= hit_cnt + 32'd1;
            end else if (!hit && (miss_cnt != '1)) begin
                miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dcache_wt_ctrl.sv
// Self-checking bench for dcache_wt_ctrl: directed cases then randomized traffic
// against a line-level cache/memory reference model.
module tb_dcache_wt_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] cpu_addr;
    logic        cpu_read;
    logic        cpu_write;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    dcache_wt_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu_addr  (cpu_addr),
        .cpu_read  (cpu_read),
        .cpu_write (cpu_write),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .stall     (stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Transactions are {we, word address, write data (0 for reads)}.
    logic [64:0] exp_q [$];
    logic [64:0] obs_q [$];

    logic [31:0] mem_model [logic [31:0]];
    logic [31:0] ref_mem   [logic [31:0]];
    logic        ref_valid [32];
    logic [22:0] ref_tag   [32];

    int lat_fixed = 2;
    bit lat_rand  = 1'b0;
    int lat_cnt   = -1;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, a[15:0]};
    endfunction

    task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Memory responder: random or fixed wait, then a one-cycle mem_ready pulse.
    initial begin
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_ready = 1'b0;
            if (!rst_n || !mem_req) begin
                lat_cnt = -1;
            end else begin
                if (lat_cnt < 0) lat_cnt = lat_rand ? int'($urandom_range(0, 3)) : lat_fixed;
                if (lat_cnt == 0) begin
                    if (mem_we) mem_model[mem_addr] = mem_wdata;
                    else mem_rdata = mem_model.exists(mem_addr) ? mem_model[mem_addr] : init_word(mem_addr);
                    obs_q.push_back({mem_we, mem_addr, mem_we ? mem_wdata : 32'h0});
                    mem_ready = 1'b1;
                    lat_cnt   = -1;
                end else begin
                    lat_cnt--;
                end
            end
        end
    end

    function automatic logic [31:0] ref_get(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    task automatic ref_clear();
        for (int i = 0; i < 32; i++) ref_valid[i] = 1'b0;
    endtask

    task automatic ref_read(input logic [31:0] a, output bit hit, output logic [31:0] data);
        logic [4:0]  idx;
        logic [22:0] tg;
        idx = a[8:4];
        tg  = a[31:9];
        hit = ref_valid[idx] && (ref_tag[idx] == tg);
        if (!hit) begin
            for (int k = 0; k < 4; k++) exp_q.push_back({1'b0, a[31:4], 2'(k), 2'b00, 32'h0});
            ref_valid[idx] = 1'b1;
            ref_tag[idx]   = tg;
        end
        data = ref_get({a[31:2], 2'b00});
    endtask

    task automatic ref_write(input logic [31:0] a, input logic [31:0] d);
        ref_mem[{a[31:2], 2'b00}] = d;
        exp_q.push_back({1'b1, a[31:2], 2'b00, d});
    endtask

    task automatic check_txns(input string tag);
        check({tag, "_txn_count"}, 65'(obs_q.size()), 65'(exp_q.size()));
        while (obs_q.size() > 0 && exp_q.size() > 0) check({tag, "_txn"}, obs_q.pop_front(), exp_q.pop_front());
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] data, output int stalls, output bit done);
        @(posedge clk);
        #1;
        cpu_addr  = a;
        cpu_read  = 1'b1;
        cpu_write = 1'b0;
        stalls    = 0;
        done      = 1'b0;
        data      = '0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!stall) begin
                data = cpu_rdata;
                done = 1'b1;
                break;
            end
            stalls++;
        end
        @(posedge clk);
        #1;
        cpu_read = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input bit also_read,
                            output int stalls, output bit done);
        @(posedge clk);
        #1;
        cpu_addr  = a;
        cpu_wdata = d;
        cpu_write = 1'b1;
        cpu_read  = also_read;
        stalls    = 0;
        done      = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!stall) begin
                done = 1'b1;
                break;
            end
            stalls++;
        end
        @(posedge clk);
        #1;
        cpu_write = 1'b0;
        cpu_read  = 1'b0;
    endtask

    task automatic read_op(input string tag, input logic [31:0] a);
        bit          exp_hit;
        bit          done;
        logic [31:0] exp_data;
        logic [31:0] data;
        int          stalls;
        ref_read(a, exp_hit, exp_data);
        do_read(a, data, stalls, done);
        check({tag, "_done"}, 65'(done), 65'd1);
        check({tag, "_rdata"}, 65'(data), 65'(exp_data));
        check({tag, "_hit_no_stall"}, 65'(stalls == 0), 65'(exp_hit));
        check_txns(tag);
    endtask

    task automatic write_op(input string tag, input logic [31:0] a, input logic [31:0] d, input bit also_read);
        bit done;
        int stalls;
        ref_write(a, d);
        do_write(a, d, also_read, stalls, done);
        check({tag, "_done"}, 65'(done), 65'd1);
        check_txns(tag);
    endtask

    initial begin
        bit          done;
        int          stalls;
        logic [31:0] data;
        logic [31:0] a;
        int          op;

        rst_n     = 1'b0;
        cpu_addr  = '0;
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
        cpu_wdata = '0;
        ref_clear();
        for (int k = 0; k < 4; k++) begin
            mem_model[32'h40 + 32'(4 * k)] = 32'(17 * (k + 1));
            ref_mem[32'h40 + 32'(4 * k)]   = 32'(17 * (k + 1));
        end

        repeat (3) @(negedge clk);
        check("reset_stall", 65'(stall), 65'd0);
        check("reset_mem_req", 65'(mem_req), 65'd0);
        check("reset_mem_we", 65'(mem_we), 65'd0);
        check("reset_rdata", 65'(cpu_rdata), 65'd0);
        rst_n = 1'b1;

        // Cold read: four beats at 2-cycle latency each, then a hit.
        exp_q.push_back({1'b0, 32'h40, 32'h0});
        exp_q.push_back({1'b0, 32'h44, 32'h0});
        exp_q.push_back({1'b0, 32'h48, 32'h0});
        exp_q.push_back({1'b0, 32'h4C, 32'h0});
        ref_valid[4] = 1'b1;
        ref_tag[4]   = '0;
        do_read(32'h40, data, stalls, done);
        check("cold_done", 65'(done), 65'd1);
        check("cold_rdata", 65'(data), 65'h11);
        check("cold_stall_cycles", 65'(stalls), 65'd13);
        check_txns("cold");

        do_read(32'h48, data, stalls, done);
        check("reread_rdata", 65'(data), 65'h33);
        check("reread_stall_cycles", 65'(stalls), 65'd0);
        check_txns("reread");

        ref_write(32'h44, 32'hDEADBEEF);
        do_write(32'h44, 32'hDEADBEEF, 1'b0, stalls, done);
        check("st_hit_done", 65'(done), 65'd1);
        check("st_hit_stall_cycles", 65'(stalls), 65'd4);
        check_txns("st_hit");
        @(negedge clk);
        check("after_wdone_req", 65'(mem_req), 65'd0);
        check("after_wdone_stall", 65'(stall), 65'd0);
        read_op("rd_after_st", 32'h44);

        write_op("st_miss", 32'h1000, 32'hCAFE0001, 1'b0);
        read_op("rd_no_alloc", 32'h1000);

        write_op("dual", 32'h40, 32'h5555AAAA, 1'b1);
        read_op("rd_after_dual", 32'h40);

        // Reset during beat 2 of a fill.
        @(posedge clk);
        #1;
        cpu_addr = 32'h80;
        cpu_read = 1'b1;
        done     = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (obs_q.size() >= 2) begin
                done = 1'b1;
                break;
            end
        end
        check("rst_fill_progress", 65'(done), 65'd1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_req", 65'(mem_req), 65'd0);
        check("rst_async_stall", 65'(stall), 65'd0);
        cpu_read = 1'b0;
        exp_q.push_back({1'b0, 32'h80, 32'h0});
        exp_q.push_back({1'b0, 32'h84, 32'h0});
        check_txns("rst_fill");
        ref_clear();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        read_op("rd_after_rst", 32'h40);

        // Randomized traffic over a few conflicting tags and indices.
        lat_rand = 1'b1;
        for (int n = 0; n < 60; n++) begin
            a  = {23'($urandom_range(0, 2)), 5'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'b00};
            op = int'($urandom_range(0, 9));
            if (op < 3) write_op("rnd_wr", a, $urandom, 1'b0);
            else if (op == 3) write_op("rnd_dual", a, $urandom, 1'b1);
            else read_op("rnd_rd", a);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
